// File: rtl/csa_pkg.sv
// Shared types and helpers for the carry-save accumulator.
package csa_pkg;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Widest operand/accumulator the helpers handle.
  localparam int MAX_W = 64;

  // Widen an n-bit value to MAX_W bits; callers truncate to their own width.
  function automatic logic [MAX_W-1:0] extend(input logic [MAX_W-1:0] v,
                                              input int n, input bit sgn);
    logic [MAX_W-1:0] r;
    logic             msb;
    r   = '0;
    msb = v[n-1];
    for (int i = 0; i < MAX_W; i++) begin
      if (i < n) r[i] = v[i];
      else       r[i] = sgn & msb;
    end
    return r;
  endfunction

  // Saturation ceiling for a w-bit counter: 2^w - 1.
  function automatic logic [MAX_W-1:0] count_max(input int w);
    return (MAX_W'(1) << w) - MAX_W'(1);
  endfunction

endpackage

// File: rtl/carry_save_adder_l2.sv
// 3:2 carry-save compressor: one full adder per bit, no carry ripple.
module carry_save_adder_l2 #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign carry[i] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

endmodule

// File: rtl/carry_save_accumulator.sv
// Streaming accumulator: running total kept as (sum, carry), resolved once
// per packet by a single carry-propagate add.
module carry_save_accumulator
  import csa_pkg::*;
#(
  parameter int N      = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(count_max(CNT_W));

  state_t           state;
  logic [ACC_W-1:0] s_q;
  logic [ACC_W-1:0] c_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dropped_q;

  logic [ACC_W-1:0] x;
  logic [ACC_W-1:0] csa_sum;
  logic [ACC_W-1:0] csa_carry;
  logic [ACC_W:0]   resolved;

  assign x        = ACC_W'(extend(MAX_W'(in_data), N, SIGNED != 0));
  assign in_ready = (state == ACCUM) && !rst;

  // Carry-propagate add only reads the registered pair, so it stays off
  // the one-FA-deep accumulate loop.
  assign resolved = {1'b0, s_q} + {1'b0, c_q};

  carry_save_adder_l2 #(.N(ACC_W)) u_csa (
    .a     (s_q),
    .b     (c_q),
    .c     (x),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  // Control FSM plus accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      s_q       <= '0;
      c_q       <= '0;
      cnt_q     <= '0;
      dropped_q <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            s_q <= csa_sum;
            // Top carry bit has no home in ACC_W bits: it is a 2^ACC_W wrap.
            c_q <= {csa_carry[ACC_W-2:0], 1'b0};
            if (csa_carry[ACC_W-1]) dropped_q <= 1'b1;
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
            if (in_last) state <= RESOLVE;
          end
        end
        RESOLVE: begin
          out_sum   <= resolved[ACC_W-1:0];
          out_ovf   <= (SIGNED != 0) ? 1'b0 : (dropped_q | resolved[ACC_W]);
          out_count <= cnt_q;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            s_q       <= '0;
            c_q       <= '0;
            cnt_q     <= '0;
            dropped_q <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_carry_save_accumulator.sv
// Bench: unsigned and signed instances share one stimulus stream; a packet
// level model predicts handshakes and results every cycle.
module tb_carry_save_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready0, out_valid0, out_ovf0;
  logic [15:0] out_sum0;
  logic [7:0]  out_count0;
  logic        in_ready1, out_valid1, out_ovf1;
  logic [15:0] out_sum1;
  logic [7:0]  out_count1;

  int checks = 0;
  int passes = 0;
  bit rnd_ready = 0;

  always #5 clk = ~clk;

  carry_save_accumulator #(.N(8), .ACC_W(16), .CNT_W(8), .SIGNED(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .out_sum(out_sum0), .out_count(out_count0),
    .out_ovf(out_ovf0));

  carry_save_accumulator #(.N(8), .ACC_W(16), .CNT_W(8), .SIGNED(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid1),
    .out_ready(out_ready), .out_sum(out_sum1), .out_count(out_count1),
    .out_ovf(out_ovf1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- packet-level reference model ----------------
  int          cyc = 0;
  bit          busy = 0;
  int          t_last = 0;
  int          n_ops = 0;
  int          usum = 0;
  int          ssum = 0;
  logic [15:0] e_sum0, e_sum1;
  logic [7:0]  e_cnt;
  logic        e_ovf;

  always @(negedge clk) begin
    bit ev;
    cyc++;
    if (rst) begin
      chk("in_ready0_rst", in_ready0, 0);
      chk("in_ready1_rst", in_ready1, 0);
      busy = 0; n_ops = 0; usum = 0; ssum = 0;
    end else begin
      ev = busy && (cyc >= t_last + 2);
      chk("out_valid0", out_valid0, ev);
      chk("out_valid1", out_valid1, ev);
      chk("in_ready0", in_ready0, !busy);
      chk("in_ready1", in_ready1, !busy);
      if (ev) begin
        chk("m_sum0", out_sum0, e_sum0);
        chk("m_cnt0", out_count0, e_cnt);
        chk("m_ovf0", out_ovf0, e_ovf);
        chk("m_sum1", out_sum1, e_sum1);
        chk("m_cnt1", out_count1, e_cnt);
        chk("m_ovf1", out_ovf1, 0);
      end
      if (!busy && in_valid) begin
        n_ops++;
        usum += int'(in_data);
        ssum += int'($signed(in_data));
        if (in_last) begin
          e_sum0 = usum[15:0];
          e_sum1 = ssum[15:0];
          e_ovf  = (usum >= 65536);
          e_cnt  = (n_ops > 255) ? 8'd255 : 8'(n_ops);
          busy = 1; t_last = cyc;
          n_ops = 0; usum = 0; ssum = 0;
        end
      end else if (ev && out_ready) begin
        busy = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, inout int stalls);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    @(negedge clk);
    while (!in_ready0 && n < 50) begin
      tick(); @(negedge clk); n++;
    end
    if (n >= 50) chk("accept_timeout", 1, 0);
    stalls += n;
    tick();
  endtask

  task automatic send_rep(input logic [7:0] d, input int cnt, inout int stalls);
    for (int i = 0; i < cnt; i++) send_beat(d, (i == cnt - 1), stalls);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    while (!out_valid0 && n < 20) begin
      tick(); @(negedge clk); n++;
    end
    if (n >= 20) chk("result_timeout", 1, 0);
  endtask

  task automatic check_result(input string tag, input logic [15:0] s0, input logic [7:0] c,
                              input logic ov, input logic [15:0] s1);
    chk({tag, "_sum0"}, out_sum0, s0);
    chk({tag, "_cnt0"}, out_count0, c);
    chk({tag, "_ovf0"}, out_ovf0, ov);
    chk({tag, "_sum1"}, out_sum1, s1);
    chk({tag, "_ovf1"}, out_ovf1, 0);
  endtask

  task automatic do_result(input string tag, input logic [15:0] s0, input logic [7:0] c,
                           input logic ov, input logic [15:0] s1, output int n);
    wait_valid(n);
    check_result(tag, s0, c, ov, s1);
    tick();
  endtask

  initial begin
    int st, n;
    logic [7:0] d;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", in_ready0, 1);
    chk("post_rst_sum", out_sum0, 0);
    chk("post_rst_cnt", out_count0, 0);
    tick();

    // 3 + 5 + 7, result exactly two cycles after the last accept
    st = 0;
    send_beat(8'd3, 0, st); send_beat(8'd5, 0, st); send_beat(8'd7, 1, st);
    do_result("p357", 16'd15, 8'd3, 0, 16'd15, n);
    chk("p357_latency", n, 1);

    // count saturation and wrap boundaries with 0xFF operands
    st = 0; send_rep(8'hFF, 256, st);
    chk("p256_stalls", st, 0);
    do_result("p256", 16'hFF00, 8'd255, 0, 16'hFF00, n);
    st = 0; send_rep(8'hFF, 258, st);
    do_result("p258", 16'h00FE, 8'd255, 1, 16'hFEFE, n);
    st = 0; send_rep(8'hFF, 257, st);
    do_result("p257", 16'hFFFF, 8'd255, 0, 16'hFEFF, n);

    // sign extension: 0x80 + 0x01
    st = 0; send_beat(8'h80, 0, st); send_beat(8'h01, 1, st);
    do_result("psgn", 16'h0081, 8'd2, 0, 16'hFF81, n);

    // backpressure: result held five cycles
    out_ready = 1'b0;
    st = 0; send_beat(8'd10, 0, st); send_beat(8'd20, 1, st);
    wait_valid(n);
    check_result("bp0", 16'd30, 8'd2, 0, 16'd30);
    for (int i = 0; i < 5; i++) begin
      tick(); @(negedge clk);
      check_result("bp_hold", 16'd30, 8'd2, 0, 16'd30);
      chk("bp_in_ready", in_ready0, 0);
      chk("bp_valid", out_valid0, 1);
    end
    tick(); out_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_hs", out_valid0, 1);
    tick(); @(negedge clk);
    chk("bp_ready_after", in_ready0, 1);
    chk("bp_valid_after", out_valid0, 0);
    tick();

    // aborted packet: reset mid-stream, then a single-operand packet
    st = 0; send_beat(8'd4, 0, st); send_beat(8'd6, 0, st);
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    send_beat(8'd9, 1, st);
    do_result("pabort", 16'd9, 8'd1, 0, 16'd9, n);

    // randomized packets, gaps, backpressure and occasional resets
    rnd_ready = 1;
    for (int p = 0; p < 60; p++) begin
      int len = $urandom_range(1, 6);
      if ($urandom_range(0, 9) == 0) len = $urandom_range(250, 260);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0; tick();
        end
        d = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 2) == 0) d = 8'hFF;
        send_beat(d, (b == len - 1), st);
      end
      in_valid = 1'b0; in_last = 1'b0;
      if ($urandom_range(0, 14) == 0) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end
    end
    rnd_ready = 0; out_ready = 1'b1; in_valid = 1'b0;
    repeat (6) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/carry_save_accumulator.md
# carry_save_accumulator

Streaming multi-operand accumulator built around the 3:2 carry-save compressor `carry_save_adder_l2`. It accepts one N-bit operand per cycle over a valid/ready handshake and holds the running total in redundant (sum, carry) form, so the per-operand critical path is a single full-adder delay. On the last operand of a packet it resolves the redundant pair with one carry-propagate add and presents the result, operand count and overflow flag on an output handshake. It sits between operand producers (partial-product and checksum streams) and consumers that need one binary total per packet.

## Interface
Parameters:
- `N`, 8, operand width in bits.
- `ACC_W`, 16, accumulator and result width; must be ≥ N.
- `CNT_W`, 8, width of the operand counter.
- `SIGNED`, 0, 1 selects sign extension of operands, 0 selects zero extension.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand present.
- `in_ready`  out  1  block can accept an operand.
- `in_data`  in  N  operand.
- `in_last`  in  1  marks the final operand of a packet; sampled only on an accepted beat.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  ACC_W  packet total, modulo 2^ACC_W.
- `out_count`  out  CNT_W  number of operands in the packet, saturating.
- `out_ovf`  out  1  unsigned wrap occurred; tied to 0 when SIGNED=1.

## Operation
- States: ACCUM, RESOLVE, HOLD.
- ACCUM: `in_ready`=1. An operand is accepted on a cycle with `in_valid` && `in_ready`.
- On accept, x = in_data extended to ACC_W.
  - S ← S ^ C ^ x.
  - C ← (maj(S,C,x) << 1), truncated to ACC_W.
  - Bit ACC_W-1 of maj is dropped; if it is 1, the sticky `dropped` flag is set.
  - count ← count+1, saturating at 2^CNT_W−1.
- Accept with `in_last`=1 → RESOLVE.
- RESOLVE:
  - `in_ready`=0.
  - {cout, out_sum} ← S + C.
  - `out_ovf` ← dropped | cout (SIGNED=0 only).
  - `out_count` ← count.
  - → HOLD.
- HOLD:
  - `out_valid`=1; `in_ready`=0.
  - `out_sum`, `out_count` and `out_ovf` hold stable until `out_valid` && `out_ready`.
  - On that handshake: clear S, C, count and dropped; → ACCUM.
- A single-operand packet (`in_last` on the first beat) is legal and produces result = x, count = 1.
- `in_valid` while `in_ready`=0 is ignored; the producer must hold the operand.

## Timing
- Reset (`rst`=1 at an edge):
  - state ← ACCUM.
  - S, C, count, dropped, `out_sum`, `out_count`, `out_ovf` ← 0.
  - `out_valid`=0.
  - `in_ready`=0 while `rst` is high; 1 in the first cycle after release.
- Reset mid-packet or in HOLD discards all partial state; no result is emitted.
- Throughput: one operand per cycle in ACCUM.
- Latency, with last-operand accept at cycle t:
  - RESOLVE at t+1.
  - `out_valid`=1 from t+2.
  - With `out_ready` already high, the handshake occurs at t+2 and `in_ready`=1 at t+3.
- Minimum inter-packet bubble: 2 cycles (t+1, t+2).
- `out_valid` never drops without a handshake, except under reset.

## Structure
- Package `csa_pkg`:
  - state enum {ACCUM, RESOLVE, HOLD}.
  - an `extend` function (N→ACC_W, signed/unsigned).
  - the saturating-increment constant 2^CNT_W−1.
- Sub-module: one `carry_save_adder_l2` instance with N=ACC_W, wired a=S, b=C, c=x. Its `carry` output is shifted left by one at the register input.
- The final carry-propagate add is a plain `+` in the top module. It is registered and isolated from the carry-save loop so the loop stays one FA deep.

## Test plan
Defaults N=8, ACC_W=16, CNT_W=8 unless noted.
- SIGNED=0; operands 3, 5, 7 (last on 7) → out_sum=15, out_count=3, out_ovf=0, `out_valid` exactly 2 cycles after the last accept.
- 256 back-to-back operands of 0xFF, in_valid continuous → out_sum=0xFF00, out_count=255 (saturated), out_ovf=0; `in_ready` stays high for all 256 beats.
- 258 operands of 0xFF → out_sum=0x00FE, out_ovf=1; 257 operands of 0xFF → out_sum=0xFFFF, out_ovf=0.
- SIGNED=1; operands 0x80, 0x01 → out_sum=0xFF81 (−127), out_ovf=0.
- Backpressure: result ready, `out_ready` low for 5 cycles → `out_valid`=1 and outputs stable throughout, `in_ready`=0; `out_ready` high → handshake, `in_ready`=1 the next cycle.
- Operands 4, 6 without `in_last`, then `rst` for 1 cycle, then single operand 9 with `in_last` → out_sum=9, out_count=1; no output for the aborted packet.
